// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared key codes and FSM state encoding for the keypad entry controller.
package keypad_entry_ctrl_pkg;

    localparam logic [7:0] KeyDigit0 = 8'h30;
    localparam logic [7:0] KeyDigit9 = 8'h39;
    localparam logic [7:0] KeyStar   = 8'h2A;
    localparam logic [7:0] KeyHash   = 8'h23;
    localparam logic [7:0] KeyA      = 8'h41;
    localparam logic [7:0] KeyB      = 8'h42;
    localparam logic [7:0] KeyC      = 8'h43;
    localparam logic [7:0] KeyD      = 8'h44;
    localparam logic [7:0] KeyX      = 8'h58;

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StCheck,
        StGranted,
        StDenied,
        StLockout
    } state_e;

endpackage

// File: rtl/keypad_entry_ctrl_gate.sv
// Press/release gate: one accept pulse per key press; re-arms only after the
// scanner strobe has stayed low for RELEASE_CYCLES consecutive cycles.
module key_release_gate #(
    parameter int unsigned RELEASE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid,
    output logic accept
);

    localparam int unsigned CW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CW-1:0] RelLast = CW'(RELEASE_CYCLES - 1);

    logic          armed_q, armed_d;
    logic [CW-1:0] rel_q, rel_d;

    assign accept = armed_q & key_valid;

    always_comb begin
        armed_d = armed_q;
        rel_d   = rel_q;
        if (key_valid) begin
            rel_d   = '0;
            armed_d = 1'b0;
        end else if (!armed_q) begin
            if (rel_q == RelLast) begin
                armed_d = 1'b1;
                rel_d   = '0;
            end else begin
                rel_d = rel_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b1;
            rel_q   <= '0;
        end else begin
            armed_q <= armed_d;
            rel_q   <= rel_d;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad access-code controller: collects BCD digits, checks them against a
// reference code, pulses unlock or error, and locks out after repeated failures.
module keypad_entry_ctrl
    import keypad_entry_ctrl_pkg::*;
#(
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned RELEASE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned HOLD_CYCLES    = 150000000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_CYCLES    = 1500000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            key_valid,
    input  logic [7:0]                      key_code,
    input  logic [4*CODE_LEN-1:0]           code_ref,
    output logic [4*CODE_LEN-1:0]           entry_buf,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_count,
    output logic                            unlock,
    output logic                            error,
    output logic                            locked
);

    localparam int unsigned BW = 4 * CODE_LEN;
    localparam int unsigned DW = $clog2(CODE_LEN + 1);
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [DW-1:0] DigFull  = DW'(CODE_LEN);
    localparam logic [FW-1:0] FailMax  = FW'(MAX_FAILS);
    localparam logic [TW-1:0] ToLast   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LockLast = LW'(LOCK_CYCLES - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] to_q, to_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          accept;
    logic          is_digit;
    logic          key_live;

    key_release_gate #(
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_gate (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .accept   (accept)
    );

    assign is_digit = (key_code >= KeyDigit0) && (key_code <= KeyDigit9);
    // The gate keeps tracking in every state; only IDLE/ENTRY act on keys.
    assign key_live = accept && ((state_q == StIdle) || (state_q == StEntry));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            buf_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            to_q    <= '0;
            hold_q  <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
            hold_q  <= hold_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        to_d    = '0;
        hold_d  = '0;
        lock_d  = '0;
        unique case (state_q)
            StIdle, StEntry: begin
                if (key_live) begin
                    case (key_code)
                        KeyStar: begin
                            buf_d   = '0;
                            cnt_d   = '0;
                            state_d = StIdle;
                        end
                        KeyHash: begin
                            if (state_q == StEntry) state_d = StCheck;
                        end
                        KeyA, KeyB, KeyC, KeyD, KeyX: ;
                        default: begin
                            if (is_digit && (cnt_q != DigFull)) begin
                                buf_d   = BW'({buf_q, key_code[3:0]});
                                cnt_d   = cnt_q + DW'(1);
                                state_d = StEntry;
                            end
                        end
                    endcase
                end else if (state_q == StEntry) begin
                    if (to_q == ToLast) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
            StCheck: begin
                if ((cnt_q == DigFull) && (buf_q == code_ref)) begin
                    state_d = StGranted;
                    fail_d  = '0;
                end else begin
                    state_d = StDenied;
                end
            end
            StGranted: begin
                if (hold_q == HoldLast) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            StDenied: begin
                buf_d = '0;
                cnt_d = '0;
                if (fail_q != FailMax) fail_d = fail_q + FW'(1);
                state_d = (fail_d == FailMax) ? StLockout : StIdle;
            end
            StLockout: begin
                if (lock_q == LockLast) begin
                    fail_d  = '0;
                    state_d = StIdle;
                end else begin
                    lock_d = lock_q + LW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unlock = 1'b0;
        error  = 1'b0;
        locked = 1'b0;
        unique case (state_q)
            StGranted: unlock = 1'b1;
            StDenied:  error  = 1'b1;
            StLockout: locked = 1'b1;
            default: ;
        endcase
    end

    assign entry_buf   = buf_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus random key presses,
// checked every cycle against a timestamp-based behavioural model.
module tb_keypad_entry_ctrl;

    localparam int unsigned CODE_LEN       = 4;
    localparam int unsigned RELEASE_CYCLES = 4;
    localparam int unsigned TIMEOUT_CYCLES = 100;
    localparam int unsigned HOLD_CYCLES    = 10;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned LOCK_CYCLES    = 50;
    localparam logic [15:0] CODE_REF       = 16'h1234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [15:0] entry_buf;
    logic [2:0]  digit_count;
    logic        unlock;
    logic        error;
    logic        locked;

    keypad_entry_ctrl #(
        .CODE_LEN      (CODE_LEN),
        .RELEASE_CYCLES(RELEASE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .MAX_FAILS     (MAX_FAILS),
        .LOCK_CYCLES   (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .code_ref   (CODE_REF),
        .entry_buf  (entry_buf),
        .digit_count(digit_count),
        .unlock     (unlock),
        .error      (error),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_unl = 0;
    int n_errp = 0;
    int n_lockc = 0;

    // Model: entered digits, fail count, and absolute cycle windows of outputs.
    int m_digits[$];
    int m_fails, m_last, m_busy_end, m_clear_at;
    int m_unl_s, m_unl_e, m_lck_s, m_lck_e, m_err_c;
    bit m_armed;
    int m_low;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] m_buf();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return 16'(v);
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_fails = 0; m_last = 0; m_busy_end = -1; m_clear_at = -1;
        m_unl_s = -1; m_unl_e = -2; m_lck_s = -1; m_lck_e = -2; m_err_c = -1;
        m_armed = 1'b1; m_low = 0;
    endtask

    task automatic model_key(input logic [7:0] kc);
        if (kc >= 8'h30 && kc <= 8'h39) begin
            if (m_digits.size() < CODE_LEN) m_digits.push_back(int'(kc) - 48);
        end else if (kc == 8'h2A) begin
            m_digits.delete();
        end else if (kc == 8'h23 && m_digits.size() > 0) begin
            if (m_digits.size() == CODE_LEN && m_buf() == CODE_REF) begin
                m_fails = 0;
                m_unl_s = cyc + 2;
                m_unl_e = cyc + 1 + HOLD_CYCLES;
                m_busy_end = m_unl_e;
                m_clear_at = m_unl_e + 1;
            end else begin
                m_fails++;
                m_err_c = cyc + 2;
                m_busy_end = cyc + 2;
                m_clear_at = cyc + 3;
                if (m_fails == MAX_FAILS) begin
                    m_lck_s = cyc + 3;
                    m_lck_e = cyc + 2 + LOCK_CYCLES;
                    m_busy_end = m_lck_e;
                    m_fails = 0;
                end
            end
        end
        m_last = cyc;
    endtask

    // One clock cycle: called at a falling edge, compares, then drives inputs.
    task automatic step(input logic kv, input logic [7:0] kc);
        bit acc;
        if (cyc == m_clear_at) m_digits.delete();
        if (m_digits.size() != 0 && cyc > m_busy_end && cyc == m_last + TIMEOUT_CYCLES + 1)
            m_digits.delete();
        check_eq("entry_buf", 32'(entry_buf), 32'(m_buf()));
        check_eq("digit_count", 32'(digit_count), 32'(m_digits.size()));
        check_eq("unlock", 32'(unlock), 32'(cyc >= m_unl_s && cyc <= m_unl_e));
        check_eq("error", 32'(error), 32'(cyc == m_err_c));
        check_eq("locked", 32'(locked), 32'(cyc >= m_lck_s && cyc <= m_lck_e));
        if (unlock) n_unl++;
        if (error) n_errp++;
        if (locked) n_lockc++;
        key_valid = kv;
        key_code = kc;
        acc = m_armed && kv;
        if (kv) begin
            m_low = 0;
            m_armed = 1'b0;
        end else if (!m_armed) begin
            m_low++;
            if (m_low == RELEASE_CYCLES) begin
                m_armed = 1'b1;
                m_low = 0;
            end
        end
        if (acc && cyc > m_busy_end) model_key(kc);
        @(negedge clk);
        cyc++;
    endtask

    task automatic press(input logic [7:0] kc, input int hold, input int gap);
        repeat (hold) step(1'b1, kc);
        repeat (gap) step(1'b0, kc);
    endtask

    task automatic press_seq(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i], 6, 5);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_valid = 1'b0;
        #1;
        check_eq("rst_unlock", 32'(unlock), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_entry_buf", 32'(entry_buf), 32'd0);
        check_eq("rst_digit_count", 32'(digit_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [7:0] letters [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h58};

    initial begin
        int base_u, base_e, base_l, budget;
        model_reset();
        @(negedge clk);
        do_reset();

        // Correct code: buffer shows 1234 and unlock lasts HOLD_CYCLES.
        base_u = n_unl;
        press_seq("1234#");
        repeat (20) step(1'b0, 8'h00);
        check_eq("unlock_len", 32'(n_unl - base_u), 32'(HOLD_CYCLES));

        // Held key counts once; 3-cycle release is too short, 4 re-arms.
        press("5", 20, 3);
        press("6", 2, 4);
        check_eq("dc_short_gap", 32'(digit_count), 32'd1);
        press("6", 2, 4);
        check_eq("dc_full_gap", 32'(digit_count), 32'd2);
        press_seq("*");

        // Three wrong attempts -> three errors and a lockout ignoring keys.
        base_e = n_errp;
        base_l = n_lockc;
        repeat (3) press_seq("9999#");
        press_seq("1234#");
        repeat (60) step(1'b0, 8'h00);
        check_eq("lock_errors", 32'(n_errp - base_e), 32'd3);
        check_eq("lock_len", 32'(n_lockc - base_l), 32'(LOCK_CYCLES));
        check_eq("lock_no_unlock", 32'(unlock), 32'd0);

        // Cancel then '#' in IDLE: no error; short code: one error.
        base_e = n_errp;
        press_seq("12*#");
        check_eq("cancel_dc", 32'(digit_count), 32'd0);
        check_eq("cancel_no_err", 32'(n_errp - base_e), 32'd0);
        press_seq("12#");
        repeat (5) step(1'b0, 8'h00);
        check_eq("short_code_err", 32'(n_errp - base_e), 32'd1);

        // Inactivity timeout, then a fifth digit is ignored.
        base_e = n_errp;
        press_seq("12");
        repeat (105) step(1'b0, 8'h00);
        check_eq("timeout_dc", 32'(digit_count), 32'd0);
        check_eq("timeout_no_err", 32'(n_errp - base_e), 32'd0);
        press_seq("12345");
        check_eq("full_buf", 32'(entry_buf), 32'h1234);
        check_eq("full_dc", 32'(digit_count), 32'd4);
        press_seq("*");

        // Reset during the fifth unlock cycle.
        press_seq("1234");
        base_u = n_unl;
        repeat (6) step(1'b1, 8'h23);
        budget = 40;
        while (n_unl - base_u < 5 && budget > 0) begin
            step(1'b0, 8'h00);
            budget--;
        end
        check_eq("unlock_wait", 32'(budget > 0), 32'd1);
        check_eq("unlock_pre_rst", 32'(unlock), 32'd1);
        do_reset();
        press("1", 6, 5);
        check_eq("post_rst_dc", 32'(digit_count), 32'd1);
        check_eq("post_rst_buf", 32'(entry_buf), 32'h0001);

        // Random presses.
        for (int n = 0; n < 250; n++) begin
            int r;
            logic [7:0] kc;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                press_seq("1234#");
            end else if (r == 1) begin
                repeat (110) step(1'b0, 8'h00);
            end else begin
                if (r < 8) kc = 8'(8'h30 + $urandom_range(0, 5));
                else if (r < 10) kc = 8'h23;
                else if (r < 11) kc = 8'h2A;
                else if (r < 13) kc = letters[$urandom_range(0, 4)];
                else if (r < 14) kc = 8'($urandom_range(0, 255));
                else kc = 8'(8'h31 + $urandom_range(0, 3));
                press(kc, $urandom_range(1, 8), $urandom_range(0, 7));
            end
        end
        repeat (80) step(1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: digits per access code.
REQ-002 SHALL have parameter RELEASE_CYCLES, default 500000: consecutive key_valid-low cycles required to re-arm key acceptance.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000000: entry inactivity limit.
REQ-004 SHALL have parameter HOLD_CYCLES, default 150000000: unlock pulse width.
REQ-005 SHALL have parameter MAX_FAILS, default 3: consecutive failures before lockout.
REQ-006 SHALL have parameter LOCK_CYCLES, default 1500000000: lockout duration.
REQ-007 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port key_valid, input, 1: keypad scanner detect strobe; repeats while a key is held.
REQ-010 SHALL have port key_code, input, 8: ASCII key from scanner, valid when key_valid=1.
REQ-011 SHALL have port code_ref, input, 4*CODE_LEN: reference code, BCD, most significant digit first; static during use.
REQ-012 SHALL have port entry_buf, output, 4*CODE_LEN: entered digits, BCD, left-shifted on entry.
REQ-013 SHALL have port digit_count, output, $clog2(CODE_LEN+1): number of digits held.
REQ-014 SHALL have port unlock, output, 1: high for HOLD_CYCLES on a correct code.
REQ-015 SHALL have port error, output, 1: single-cycle pulse on a failed attempt.
REQ-016 SHALL have port locked, output, 1: high throughout lockout.

Function
REQ-017 SHALL accept a key only when armed and key_valid=1; acceptance SHALL disarm; re-arm SHALL occur after RELEASE_CYCLES consecutive cycles of key_valid=0; any key_valid=1 SHALL restart the release count.
REQ-018 SHALL implement FSM IDLE, ENTRY, CHECK, GRANTED, DENIED, LOCKOUT.
REQ-019 On an accepted digit 0x30-0x39 in IDLE/ENTRY: if digit_count<CODE_LEN, entry_buf SHALL shift left 4 and load the digit, digit_count SHALL increment, state SHALL be ENTRY, all visible on the next cycle; if full, the digit SHALL be ignored.
REQ-020 On an accepted '*' (0x2A): entry_buf and digit_count SHALL clear and state SHALL return to IDLE; no failure SHALL be counted.
REQ-021 On an accepted '#' (0x23) in ENTRY: state SHALL go to CHECK; in IDLE, '#' SHALL be ignored.
REQ-022 Keys 'A'-'D' (0x41-0x44), 0x58 and all other codes SHALL be consumed (disarm) with no other effect.
REQ-023 CHECK SHALL last one cycle: digit_count==CODE_LEN and entry_buf==code_ref -> GRANTED, else -> DENIED.
REQ-024 unlock SHALL rise 2 cycles after the '#' acceptance cycle and stay high exactly HOLD_CYCLES; entering GRANTED SHALL clear the fail count; then IDLE with buffer cleared.
REQ-025 DENIED SHALL last one cycle: error=1, fail count +1, buffer cleared; next state SHALL be LOCKOUT if the new count equals MAX_FAILS, else IDLE.
REQ-026 LOCKOUT SHALL hold locked=1 for LOCK_CYCLES, ignore all keys, then clear the fail count and go to IDLE.
REQ-027 Keys SHALL be ignored in CHECK, GRANTED, DENIED and LOCKOUT, but release/arm tracking SHALL continue.
REQ-028 In ENTRY, TIMEOUT_CYCLES without an accepted key SHALL clear the buffer and return to IDLE without counting a failure; each accepted key SHALL restart the timer.
REQ-029 The fail count SHALL saturate at MAX_FAILS; timer counters SHALL be sized by $clog2 of their limits and SHALL never wrap.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, entry_buf=0, digit_count=0, unlock=0, error=0, locked=0, fail count=0, all timers=0, and key acceptance armed.
REQ-031 Reset asserted mid-GRANTED or mid-LOCKOUT SHALL drop unlock/locked asynchronously; release SHALL be synchronous to clk.

Structure
REQ-032 A shared package SHALL hold the ASCII key constants (digits, '*', '#', 'A'-'D', 0x58) and the FSM state encoding.
REQ-033 The press/release gating of REQ-017 SHALL be a sub-module key_release_gate (key_valid in, accept pulse out).

Verification (CODE_LEN=4, RELEASE_CYCLES=4, TIMEOUT_CYCLES=100, HOLD_CYCLES=10, MAX_FAILS=3, LOCK_CYCLES=50, code_ref=16'h1234)
REQ-034 Keys '1','2','3','4','#', each held 6 cycles with 5-cycle gaps -> entry_buf=16'h1234, unlock high 10 cycles starting 2 cycles after '#' acceptance.
REQ-035 '5' with key_valid held 20 cycles -> digit_count=1 exactly; a gap of 3 low cycles then '6' -> ignored; a gap of 4 low cycles then '6' -> digit_count=2.
REQ-036 Three '9','9','9','9','#' attempts -> three single-cycle error pulses; locked=1 for 50 cycles after the third attempt; keys during lockout have no effect.
REQ-037 '1','2','*','#' -> digit_count=0 after '*', state IDLE, no error; then '1','2','#' -> error pulse (short code).
REQ-038 '1','2' then 100 idle cycles -> digit_count=0, no error; '1','2','3','4','5' -> entry_buf=16'h1234 (fifth digit ignored).
REQ-039 rst_n pulled low at cycle 5 of unlock -> unlock=0 immediately; after release all outputs are zero and the next '1' is accepted.
